// File: rtl/equation2_generator.sv
// Produces X, Y, Z with X*X*Z + X*Y == T. It searches X downward from a seed.
// Division is done by repeated subtraction, so the design needs no multiplier or divider.
module equation2_generator (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Go,
  input  logic [6:0] OngoingTimer,
  input  logic [2:0] SeedX,
  output logic [7:0] DataX,
  output logic [7:0] DataY,
  output logic [7:0] DataZ,
  output logic       Busy,
  output logic       Done,
  output logic       Valid
);

  typedef enum logic [2:0] {IDLE, DIV1, CHECK, DIV2, DONE} state_t;

  state_t     state;
  logic [7:0] t;
  logic [7:0] x;
  logic [7:0] rem;
  logic [7:0] quot;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      t     <= '0;
      x     <= '0;
      rem   <= '0;
      quot  <= '0;
      DataX <= '0;
      DataY <= '0;
      DataZ <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Go) begin
            t     <= {1'b0, OngoingTimer};
            x     <= (SeedX == 3'd0) ? 8'd7 : {5'b0, SeedX};
            rem   <= {1'b0, OngoingTimer};
            quot  <= '0;
            Valid <= 1'b0;
            Busy  <= 1'b1;
            state <= DIV1;
          end
        end
        DIV1: begin
          if (rem >= x) begin
            rem  <= rem - x;
            quot <= quot + 8'd1;
          end else begin
            state <= CHECK;
          end
        end
        // The quotient t/x becomes the dividend of the second division. x=1 always ends the search.
        CHECK: begin
          if (rem == '0) begin
            rem   <= quot;
            quot  <= '0;
            state <= DIV2;
          end else begin
            x     <= x - 8'd1;
            rem   <= t;
            quot  <= '0;
            state <= DIV1;
          end
        end
        DIV2: begin
          if (rem >= x) begin
            rem  <= rem - x;
            quot <= quot + 8'd1;
          end else begin
            DataZ <= quot;
            DataY <= rem;
            DataX <= x;
            Valid <= 1'b1;
            Done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_equation2_generator.sv
// Randomized self-checking bench for equation2_generator. It compares against an arithmetic model.
module tb_equation2_generator;

  logic       Clock;
  logic       Resetn;
  logic       Go;
  logic [6:0] OngoingTimer;
  logic [2:0] SeedX;
  logic [7:0] DataX;
  logic [7:0] DataY;
  logic [7:0] DataZ;
  logic       Busy;
  logic       Done;
  logic       Valid;

  int unsigned n_vec;
  int unsigned n_err;
  int unsigned prev_x, prev_y, prev_z;

  equation2_generator dut (
    .Clock(Clock), .Resetn(Resetn), .Go(Go), .OngoingTimer(OngoingTimer),
    .SeedX(SeedX), .DataX(DataX), .DataY(DataY), .DataZ(DataZ),
    .Busy(Busy), .Done(Done), .Valid(Valid)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // The model walks X down to the largest divisor of T. The cycle count is derived from division counts.
  function automatic void model(input int t, input int s0,
                                output int ex, output int ey, output int ez, output int en);
    int x;
    x  = (s0 == 0) ? 7 : s0;
    en = 0;
    while (t % x != 0) begin
      en += t / x + 2;
      x--;
    end
    en += t / x + 2;
    ex = x;
    ez = (t / x) / x;
    ey = (t / x) % x;
    en += (t / x) / x + 1;
  endfunction

  task automatic run(input int t, input int s, input bit extra_go);
    int ex, ey, ez, en, n;
    model(t, s, ex, ey, ez, en);
    @(negedge Clock);
    OngoingTimer = 7'(t);
    SeedX        = 3'(s);
    Go           = 1'b1;
    @(posedge Clock); #1;
    Go = 1'b0;
    check("busy_after_go", Busy, 1);
    check("valid_cleared", Valid, 0);
    check("hold_x", DataX, prev_x);
    check("hold_y", DataY, prev_y);
    check("hold_z", DataZ, prev_z);
    n = 0;
    while (!Done && n < 1000) begin
      @(posedge Clock); #1;
      n++;
      if (extra_go && n == 10) begin
        OngoingTimer = 7'd36;
        SeedX        = 3'd6;
        Go           = 1'b1;
      end else begin
        Go = 1'b0;
      end
    end
    check("done_seen", Done, 1);
    check("cycles", n, en);
    check("data_x", DataX, ex);
    check("data_y", DataY, ey);
    check("data_z", DataZ, ez);
    check("valid", Valid, 1);
    check("identity", DataX * DataX * DataZ + DataX * DataY, t);
    check("y_lt_x", DataY < DataX, 1);
    @(posedge Clock); #1;
    check("done_pulse", Done, 0);
    check("busy_drop", Busy, 0);
    check("valid_hold", Valid, 1);
    prev_x = ex;
    prev_y = ey;
    prev_z = ez;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    prev_x = 0; prev_y = 0; prev_z = 0;
    Resetn = 1'b0;
    Go = 1'b0;
    OngoingTimer = '0;
    SeedX = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_x", DataX, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_valid", Valid, 0);
    @(negedge Clock);
    Resetn = 1'b1;

    run(0, 0, 1'b0);
    run(12, 5, 1'b0);
    run(1, 3, 1'b0);
    run(36, 6, 1'b0);
    run(127, 7, 1'b1);

    // Reset asynchronously in the middle of a worst-case search.
    @(negedge Clock);
    OngoingTimer = 7'd127;
    SeedX = 3'd7;
    Go = 1'b1;
    @(posedge Clock); #1;
    Go = 1'b0;
    repeat (50) @(posedge Clock);
    #2;
    Resetn = 1'b0;
    #1;
    check("arst_x", DataX, 0);
    check("arst_y", DataY, 0);
    check("arst_z", DataZ, 0);
    check("arst_busy", Busy, 0);
    check("arst_done", Done, 0);
    check("arst_valid", Valid, 0);
    @(negedge Clock);
    Resetn = 1'b1;
    prev_x = 0; prev_y = 0; prev_z = 0;
    run(36, 6, 1'b0);

    for (int i = 0; i < 20; i++)
      run(int'($urandom_range(0, 127)), int'($urandom_range(0, 7)), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
